// File: rtl/equifiller_req_scheduler.sv
// Two-requester slot scheduler in front of a fixed-latency allocator.
// Optional stats counters: define EQUIFILLER_SCHED_STATS_EN.
module equifiller_req_scheduler #(
    parameter int SLOT_CYCLES = 4,
    parameter int RESULT_LAT  = 7
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic [1:0]      req_valid_i,
    input  logic [1:0][4:0] req_height_i,
    input  logic [1:0][4:0] req_width_i,
    output logic [1:0]      req_ready_o,
    output logic [4:0]      alloc_height_o,
    output logic [4:0]      alloc_width_o,
    input  logic [3:0]      alloc_strike_i,
    input  logic [7:0]      alloc_x_i,
    input  logic [7:0]      alloc_y_i,
    output logic [1:0]      rsp_valid_o,
    output logic [3:0]      rsp_strike_o,
    output logic [7:0]      rsp_x_o,
    output logic [7:0]      rsp_y_o,
`ifdef EQUIFILLER_SCHED_STATS_EN
    output logic [15:0]     placed_cnt_o,
    output logic [15:0]     strike_cnt_o,
`endif
    output logic            busy_o
);

    localparam int PW = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;

    typedef struct packed {
        logic valid;
        logic id;
        logic rej;
    } tag_t;

    logic [PW-1:0] phase_q;
    logic          last_q;
    logic [1:0]    grant;
    logic          slot_start;
    logic          xfer;
    logic          gid;
    logic [4:0]    sel_h;
    logic [4:0]    sel_w;
    logic          rej;
    tag_t          slot_tag_q;
    tag_t          tag_q [RESULT_LAT];
    tag_t          exit_tag;

    assign slot_start = (phase_q == '0);
    assign xfer       = |grant;
    assign gid        = grant[1];
    assign sel_h      = req_height_i[gid];
    assign sel_w      = req_width_i[gid];
    assign rej        = (sel_h == 5'd0) || (sel_w == 5'd0);
    assign exit_tag   = tag_q[RESULT_LAT-1];
    assign req_ready_o = grant;

    // Round-robin grant, offered only in the first cycle of a slot
    always_comb begin
        grant = 2'b00;
        if (slot_start) begin
            unique case (req_valid_i)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = last_q ? 2'b01 : 2'b10;
                default: grant = 2'b00;
            endcase
        end
    end

    // Phase counter, last-winner pointer and allocator drive registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            phase_q        <= '0;
            last_q         <= 1'b1;
            alloc_height_o <= '0;
            alloc_width_o  <= '0;
            slot_tag_q     <= '0;
        end else begin
            if (phase_q == PW'(SLOT_CYCLES - 1)) begin
                phase_q <= '0;
            end else begin
                phase_q <= phase_q + 1'b1;
            end
            slot_tag_q <= '0;
            if (slot_start) begin
                alloc_height_o <= (xfer && !rej) ? sel_h : 5'd0;
                alloc_width_o  <= (xfer && !rej) ? sel_w : 5'd0;
                slot_tag_q     <= '{valid: xfer, id: gid, rej: rej};
                if (xfer) begin
                    last_q <= gid;
                end
            end
        end
    end

    // Tag delay line aligning each issue with its allocator result
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < RESULT_LAT; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            tag_q[0] <= slot_tag_q;
            for (int i = 1; i < RESULT_LAT; i++) begin
                tag_q[i] <= tag_q[i-1];
            end
        end
    end

    // Response register: pulse valid, payload holds between responses
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rsp_valid_o  <= '0;
            rsp_strike_o <= '0;
            rsp_x_o      <= '0;
            rsp_y_o      <= '0;
        end else begin
            rsp_valid_o <= '0;
            if (exit_tag.valid) begin
                rsp_valid_o <= exit_tag.id ? 2'b10 : 2'b01;
                if (exit_tag.rej) begin
                    rsp_strike_o <= 4'd1;
                    rsp_x_o      <= 8'd128;
                    rsp_y_o      <= 8'd128;
                end else begin
                    rsp_strike_o <= alloc_strike_i;
                    rsp_x_o      <= alloc_x_i;
                    rsp_y_o      <= alloc_y_i;
                end
            end
        end
    end

    // Busy while any issued tag is still travelling
    always_comb begin
        busy_o = slot_tag_q.valid;
        for (int i = 0; i < RESULT_LAT; i++) begin
            busy_o = busy_o | tag_q[i].valid;
        end
    end

`ifdef EQUIFILLER_SCHED_STATS_EN
    logic strike_nz;
    assign strike_nz = exit_tag.rej || (alloc_strike_i != 4'd0);

    // Saturating placement / strike counters, one step per response
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            placed_cnt_o <= '0;
            strike_cnt_o <= '0;
        end else if (exit_tag.valid) begin
            if (strike_nz) begin
                if (strike_cnt_o != 16'hFFFF) begin
                    strike_cnt_o <= strike_cnt_o + 16'd1;
                end
            end else begin
                if (placed_cnt_o != 16'hFFFF) begin
                    placed_cnt_o <= placed_cnt_o + 16'd1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_equifiller_req_scheduler.sv
// Scoreboard bench for equifiller_req_scheduler.
// Includes a fixed-latency allocator model driven from alloc outputs.
module tb_equifiller_req_scheduler;

    localparam int SC = 4;
    localparam int RL = 7;

    logic            clk;
    logic            rst_ni;
    logic [1:0]      req_valid_i;
    logic [1:0][4:0] req_height_i;
    logic [1:0][4:0] req_width_i;
    logic [1:0]      req_ready_o;
    logic [4:0]      alloc_height_o;
    logic [4:0]      alloc_width_o;
    logic [3:0]      alloc_strike_i;
    logic [7:0]      alloc_x_i;
    logic [7:0]      alloc_y_i;
    logic [1:0]      rsp_valid_o;
    logic [3:0]      rsp_strike_o;
    logic [7:0]      rsp_x_o;
    logic [7:0]      rsp_y_o;
    logic            busy_o;
`ifdef EQUIFILLER_SCHED_STATS_EN
    logic [15:0]     placed_cnt_o;
    logic [15:0]     strike_cnt_o;
`endif

    equifiller_req_scheduler #(
        .SLOT_CYCLES(SC),
        .RESULT_LAT (RL)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_ni),
        .req_valid_i   (req_valid_i),
        .req_height_i  (req_height_i),
        .req_width_i   (req_width_i),
        .req_ready_o   (req_ready_o),
        .alloc_height_o(alloc_height_o),
        .alloc_width_o (alloc_width_o),
        .alloc_strike_i(alloc_strike_i),
        .alloc_x_i     (alloc_x_i),
        .alloc_y_i     (alloc_y_i),
        .rsp_valid_o   (rsp_valid_o),
        .rsp_strike_o  (rsp_strike_o),
        .rsp_x_o       (rsp_x_o),
        .rsp_y_o       (rsp_y_o),
`ifdef EQUIFILLER_SCHED_STATS_EN
        .placed_cnt_o  (placed_cnt_o),
        .strike_cnt_o  (strike_cnt_o),
`endif
        .busy_o        (busy_o)
    );

    typedef struct {
        int         id;
        logic [3:0] s;
        logic [7:0] x;
        logic [7:0] y;
        int         gcyc;
        int         due;
    } exp_t;

    exp_t       sb [$];
    int         grant_order [$];
    int         gcount [2];
    int         last_grant_cyc;
    int         cyc;
    int         n_chk;
    int         n_fail;
    logic [19:0] last_p;
    logic [9:0] hist [0:RL];

    int         m_phase;
    logic       m_last;
    logic [4:0] m_ah;
    logic [4:0] m_aw;
    logic [1:0] m_ready;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Reference arbiter: expected ready in the current cycle
    always_comb begin
        m_ready = 2'b00;
        if (m_phase == 0) begin
            case (req_valid_i)
                2'b01:   m_ready = 2'b01;
                2'b10:   m_ready = 2'b10;
                2'b11:   m_ready = m_last ? 2'b01 : 2'b10;
                default: m_ready = 2'b00;
            endcase
        end
    end

    // Reference slot state: phase, pointer, expected allocator drive
    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            m_phase <= 0;
            m_last  <= 1'b1;
            m_ah    <= '0;
            m_aw    <= '0;
        end else begin
            m_phase <= (m_phase + 1) % SC;
            if (m_phase == 0) begin
                m_ah <= '0;
                m_aw <= '0;
                if (m_ready != 2'b00) begin
                    m_last <= m_ready[1];
                    if (req_height_i[m_ready[1]] != 0 &&
                        req_width_i[m_ready[1]] != 0) begin
                        m_ah <= req_height_i[m_ready[1]];
                        m_aw <= req_width_i[m_ready[1]];
                    end
                end
            end
        end
    end

    // Negedge monitor: responses, busy, ready, alloc drive, allocator model
    initial begin
        exp_t e;
        logic [4:0] h;
        logic [4:0] w;
        logic eb;
        for (int i = 0; i <= RL; i++) hist[i] = '0;
        alloc_strike_i = '0;
        alloc_x_i = '0;
        alloc_y_i = '0;
        forever begin
            @(negedge clk);
            if (rsp_valid_o != 2'b00) begin
                n_chk++;
                if (sb.size() == 0) begin
                    $display("FAIL unexpected_rsp valid=%b cyc=%0d", rsp_valid_o, cyc);
                    n_fail++;
                end else begin
                    e = sb.pop_front();
                    if (rsp_valid_o !== (2'b01 << e.id)) begin
                        $display("FAIL rsp_id got=%b exp=%b", rsp_valid_o, 2'b01 << e.id);
                        n_fail++;
                    end
                    n_chk++;
                    if ({rsp_strike_o, rsp_x_o, rsp_y_o} !== {e.s, e.x, e.y}) begin
                        $display("FAIL rsp_payload got=%h/%h/%h exp=%h/%h/%h",
                                 rsp_strike_o, rsp_x_o, rsp_y_o, e.s, e.x, e.y);
                        n_fail++;
                    end
                    n_chk++;
                    if (cyc != e.due) begin
                        $display("FAIL rsp_latency got_cyc=%0d exp_cyc=%0d", cyc, e.due);
                        n_fail++;
                    end
                    last_p = {e.s, e.x, e.y};
                end
            end else begin
                n_chk++;
                if ({rsp_strike_o, rsp_x_o, rsp_y_o} !== last_p) begin
                    $display("FAIL rsp_hold got=%h exp=%h",
                             {rsp_strike_o, rsp_x_o, rsp_y_o}, last_p);
                    n_fail++;
                end
                if (sb.size() > 0 && sb[0].due <= cyc) begin
                    n_chk++;
                    $display("FAIL rsp_missing got=none exp_cyc=%0d", sb[0].due);
                    n_fail++;
                    void'(sb.pop_front());
                end
            end
            eb = 1'b0;
            foreach (sb[i]) if (sb[i].gcyc <= cyc) eb = 1'b1;
            n_chk++;
            if (busy_o !== eb) begin
                $display("FAIL busy got=%b exp=%b cyc=%0d", busy_o, eb, cyc);
                n_fail++;
            end
            n_chk++;
            if (req_ready_o !== m_ready) begin
                $display("FAIL ready got=%b exp=%b cyc=%0d", req_ready_o, m_ready, cyc);
                n_fail++;
            end
            n_chk++;
            if ({alloc_height_o, alloc_width_o} !== {m_ah, m_aw}) begin
                $display("FAIL alloc got=%0d/%0d exp=%0d/%0d",
                         alloc_height_o, alloc_width_o, m_ah, m_aw);
                n_fail++;
            end
            if (rst_ni && m_ready != 2'b00) begin
                e.id = m_ready[1] ? 1 : 0;
                h = req_height_i[e.id];
                w = req_width_i[e.id];
                if (h == 0 || w == 0) begin
                    e.s = 4'd1;
                    e.x = 8'd128;
                    e.y = 8'd128;
                end else begin
                    e.s = (h > 5'd16) ? 4'd3 : 4'd0;
                    e.x = {3'b000, h} + 8'd1;
                    e.y = {3'b000, w} + 8'd2;
                end
                e.gcyc = cyc + 1;
                e.due = cyc + 1 + RL + 1;
                sb.push_back(e);
                gcount[e.id]++;
                grant_order.push_back(e.id);
                last_grant_cyc = cyc + 1;
            end
            for (int i = RL; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = {alloc_height_o, alloc_width_o};
            alloc_strike_i = (hist[RL][9:5] > 5'd16) ? 4'd3 : 4'd0;
            alloc_x_i = {3'b000, hist[RL][9:5]} + 8'd1;
            alloc_y_i = {3'b000, hist[RL][4:0]} + 8'd2;
        end
    end

    task automatic request(input int id, input logic [4:0] h, input logic [4:0] w);
        int old;
        bit got;
        old = gcount[id];
        got = 1'b0;
        @(posedge clk);
        #2;
        req_valid_i[id] = 1'b1;
        req_height_i[id] = h;
        req_width_i[id] = w;
        for (int i = 0; i < 20 && !got; i++) begin
            @(posedge clk);
            #2;
            if (gcount[id] != old) got = 1'b1;
        end
        req_valid_i[id] = 1'b0;
        n_chk++;
        if (!got) begin
            $display("FAIL grant_timeout got=none exp=grant id=%0d", id);
            n_fail++;
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && sb.size() > 0; i++) @(posedge clk);
        repeat (2) @(posedge clk);
        #2;
        n_chk++;
        if (sb.size() != 0) begin
            $display("FAIL drain_timeout got=%0d_pending exp=0", sb.size());
            n_fail++;
        end
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        req_valid_i = '0;
        req_height_i = '0;
        req_width_i = '0;
        repeat (3) @(posedge clk);
        #2;
        n_chk++;
        if ({alloc_height_o, alloc_width_o, rsp_valid_o, rsp_strike_o,
             rsp_x_o, rsp_y_o, busy_o} !== '0) begin
            $display("FAIL reset_outputs got=%b exp=0",
                     {alloc_height_o, alloc_width_o, rsp_valid_o,
                      rsp_strike_o, rsp_x_o, rsp_y_o, busy_o});
            n_fail++;
        end
        rst_ni = 1'b1;
    endtask

    task automatic test_back_to_back();
        int start;
        start = grant_order.size();
        @(posedge clk);
        #2;
        req_height_i[0] = 5'd5;
        req_width_i[0] = 5'd6;
        req_height_i[1] = 5'd7;
        req_width_i[1] = 5'd8;
        req_valid_i = 2'b11;
        for (int i = 0; i < 30 && grant_order.size() < start + 4; i++) begin
            @(posedge clk);
            #2;
        end
        req_valid_i = 2'b00;
        n_chk++;
        if (grant_order.size() < start + 4) begin
            $display("FAIL b2b_grants got=%0d exp=4", grant_order.size() - start);
            n_fail++;
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_chk++;
                if (grant_order[start+i] != i % 2) begin
                    $display("FAIL b2b_order slot=%0d got=%0d exp=%0d",
                             i, grant_order[start+i], i % 2);
                    n_fail++;
                end
            end
        end
        drain();
    endtask

    task automatic test_single();
        request(0, 5'd12, 5'd12);
        for (int i = 0; i < SC; i++) begin
            n_chk++;
            if (alloc_height_o !== 5'd12 || alloc_width_o !== 5'd12) begin
                $display("FAIL single_alloc cyc=%0d got=%0d/%0d exp=12/12",
                         i, alloc_height_o, alloc_width_o);
                n_fail++;
            end
            @(posedge clk);
            #2;
        end
        n_chk++;
        if (alloc_height_o !== 5'd0 || alloc_width_o !== 5'd0) begin
            $display("FAIL single_alloc_clear got=%0d/%0d exp=0/0",
                     alloc_height_o, alloc_width_o);
            n_fail++;
        end
        drain();
    endtask

    task automatic test_reject();
        request(1, 5'd0, 5'd5);
        n_chk++;
        if (alloc_height_o !== 5'd0 || alloc_width_o !== 5'd0) begin
            $display("FAIL reject_alloc got=%0d/%0d exp=0/0",
                     alloc_height_o, alloc_width_o);
            n_fail++;
        end
        drain();
    endtask

    task automatic test_phase();
        int start;
        int old;
        bit got;
        for (int i = 0; i < 8 && m_phase != 2; i++) begin
            @(posedge clk);
            #2;
        end
        start = cyc;
        old = gcount[0];
        got = 1'b0;
        req_height_i[0] = 5'd3;
        req_width_i[0] = 5'd9;
        req_valid_i[0] = 1'b1;
        #1;
        n_chk++;
        if (req_ready_o !== 2'b00) begin
            $display("FAIL phase2_ready got=%b exp=00", req_ready_o);
            n_fail++;
        end
        for (int i = 0; i < 10 && !got; i++) begin
            @(posedge clk);
            #2;
            if (gcount[0] != old) got = 1'b1;
        end
        req_valid_i[0] = 1'b0;
        n_chk++;
        if (!got || last_grant_cyc != start + 3) begin
            $display("FAIL phase2_grant got_cyc=%0d exp_cyc=%0d",
                     last_grant_cyc, start + 3);
            n_fail++;
        end
        drain();
    endtask

    task automatic test_reset_mid();
        request(0, 5'd9, 5'd9);
        repeat (3) @(posedge clk);
        #2;
        rst_ni = 1'b0;
        sb.delete();
        last_p = '0;
        #1;
        n_chk++;
        if ({alloc_height_o, alloc_width_o, rsp_valid_o, rsp_strike_o,
             rsp_x_o, rsp_y_o, busy_o} !== '0) begin
            $display("FAIL midreset_outputs got=%b exp=0",
                     {alloc_height_o, alloc_width_o, rsp_valid_o,
                      rsp_strike_o, rsp_x_o, rsp_y_o, busy_o});
            n_fail++;
        end
        repeat (2) @(posedge clk);
        #2;
        rst_ni = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #2;
            n_chk++;
            if (rsp_valid_o !== 2'b00 || busy_o !== 1'b0) begin
                $display("FAIL midreset_ghost cyc=%0d got=%b/%b exp=00/0",
                         i, rsp_valid_o, busy_o);
                n_fail++;
            end
        end
    endtask

`ifdef EQUIFILLER_SCHED_STATS_EN
    task automatic test_stats();
        request(0, 5'd3, 5'd4);
        request(1, 5'd10, 5'd2);
        request(0, 5'd16, 5'd16);
        request(1, 5'd20, 5'd3);
        drain();
        n_chk++;
        if (placed_cnt_o !== 16'd3 || strike_cnt_o !== 16'd1) begin
            $display("FAIL stats got=%0d/%0d exp=3/1", placed_cnt_o, strike_cnt_o);
            n_fail++;
        end
    endtask
`endif

    initial begin
        n_chk = 0;
        n_fail = 0;
        last_p = '0;
        last_grant_cyc = 0;
        gcount[0] = 0;
        gcount[1] = 0;
        rst_ni = 1'b0;
        req_valid_i = '0;
        req_height_i = '0;
        req_width_i = '0;
        test_reset();
        test_back_to_back();
        test_single();
        test_reject();
        test_phase();
        test_reset_mid();
`ifdef EQUIFILLER_SCHED_STATS_EN
        test_stats();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
